nios2_pio_in_edge_irq: RTL and testbench
========================================

// Module: nios2_pio_in_edge_irq
// PURPOSE
//  Parametrised Avalon-MM slave input port for the Nios II system; successor to the single-bit status input PIO.
//  Synchronises a WIDTH-bit external input, captures per-bit edges, and raises a maskable interrupt.
//  Sits on the system interconnect alongside the other PIO slaves. Readdata is registered.
// PARAMETERS
//  WIDTH        8   input bits, 1..32; unused readdata bits read 0
//  SYNC_STAGES  2   synchroniser flops on in_port, 2..4
//  EDGE_TYPE    0   0=rising, 1=falling, 2=any edge captured
//  IRQ_TYPE     1   0=level (sync data & mask), 1=edge (edgecapture & mask)
// PORTS
//  clk         in   1      system clock, single clock domain
//  reset_n     in   1      synchronous reset, active-low (sampled on clk rising edge)
//  address     in   2      register word offset
//  chipselect  in   1      slave select
//  write_n     in   1      active-low write strobe, qualified by chipselect
//  writedata   in   32     write data
//  in_port     in   WIDTH  asynchronous external input
//  readdata    out  32     registered read data
//  irq         out  1      interrupt request, active-high
// BEHAVIOUR
//  Register map: 0=DATA (RO, synchronised input), 1=IRQMASK (RW, WIDTH bits), 2=reserved (reads 0, writes ignored),
//   3=EDGECAPTURE (read; write-1-to-clear per bit).
//  Write = chipselect & ~write_n at the clk edge; writes to offsets 0 and 2 have no effect.
//  readdata: updated every cycle from address (independent of chipselect): mux of offset contents, zero-extended.
//   1-cycle latency: address at edge N -> readdata valid after edge N+1. Reads have no side effects.
//  Synchroniser: SYNC_STAGES-deep flop chain per bit -> sync[WIDTH-1:0]; prev = sync delayed one cycle.
//  Edge detect: rise = sync & ~prev; fall = ~sync & prev; selected per EDGE_TYPE.
//  Prime counter: after reset deassert, edge detection suppressed for SYNC_STAGES+1 cycles (chain filling);
//   an input already high at reset exit must NOT set EDGECAPTURE.
//  EDGECAPTURE bit: set on detected edge; cleared by write to offset 3 with writedata bit=1;
//   same-cycle set and clear -> set wins (bit stays 1). Bits remain set until cleared (sticky).
//  irq: combinational from registered state: IRQ_TYPE=0 -> |(sync & mask); IRQ_TYPE=1 -> |(edgecapture & mask).
//   Mask write takes effect on irq the cycle after the write edge.
//  Reset (reset_n=0 at edge): readdata=0, IRQMASK=0, EDGECAPTURE=0, sync chain=0, prev=0, prime counter reloaded;
//   hence irq=0. Reset asserted mid-operation clears all state at that edge regardless of bus activity.
//  Write data bits above WIDTH ignored; data in_port changes reach DATA after SYNC_STAGES cycles.
// STRUCTURE
//  Shared package/include: register offsets (PIO_OFF_DATA/MASK/RSVD/EDGE), EDGE_TYPE and IRQ_TYPE encodings.
//  Sub-module nios2_pio_sync_edge: synchroniser chain, prev register, prime counter, edge pulse output (WIDTH bits).
//  Top: register file, read mux + readdata register, irq logic.
// TESTING (WIDTH=8, SYNC_STAGES=2, EDGE_TYPE=0, IRQ_TYPE=1 unless noted)
//  1. Reset with in_port=8'hFF, release -> EDGECAPTURE reads 0, irq=0; DATA reads 8'hFF after 2 sync cycles + 1.
//  2. in_port 0->8'h05, mask=8'h04 -> EDGECAPTURE=8'h05, irq=1; write 8'h04 to offset 3 -> EDGECAPTURE=8'h01, irq=0.
//  3. Rising edge on bit0 same cycle as clear-write 8'h01 to offset 3 -> bit0 remains 1.
//  4. Read latency: address=1 with mask=8'hA5, chipselect=1 at edge N -> readdata=32'h000000A5 after edge N+1; address=2 -> 0.
//  5. IRQ_TYPE=0, mask=8'h80: in_port bit7 high -> irq=1 after 2 cycles; bit7 low -> irq=0; EDGE_TYPE=1/2 variants capture falling/both.
//  6. reset_n low mid-stream with EDGECAPTURE=8'hFF, mask=8'hFF -> next edge all registers 0, irq=0, readdata=0.

Source files
------------

// File: rtl/nios2_pio_in_edge_irq_pkg.sv
// Shared register offsets and edge/irq mode encodings for the edge-capturing input PIO.
// No logic, no latency, no backpressure.
package nios2_pio_in_edge_irq_pkg;

  typedef enum logic [1:0] {
    PIO_OFF_DATA = 2'd0,
    PIO_OFF_MASK = 2'd1,
    PIO_OFF_RSVD = 2'd2,
    PIO_OFF_EDGE = 2'd3
  } pio_off_e;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  localparam int IRQ_LEVEL = 0;
  localparam int IRQ_EDGE  = 1;

endpackage

// File: rtl/nios2_pio_sync_edge.sv
// Synchroniser chain + previous-value register + edge pulse, muted while the chain primes after reset.
// sync lags in_port by SYNC_STAGES cycles; edge_pulse is combinational from flops; no backpressure.
module nios2_pio_sync_edge
  import nios2_pio_in_edge_irq_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] edge_pulse
);

  localparam int                 PRIME_W    = 3;
  localparam logic [PRIME_W-1:0] PRIME_LOAD = PRIME_W'(SYNC_STAGES + 1);

  logic [WIDTH-1:0]   chain_q [SYNC_STAGES];
  logic [WIDTH-1:0]   chain_d [SYNC_STAGES];
  logic [WIDTH-1:0]   prev_q, prev_d;
  logic [PRIME_W-1:0] prime_q, prime_d;
  logic [WIDTH-1:0]   rise, fall, sel;

  assign sync = chain_q[SYNC_STAGES-1];

  always_comb begin
    chain_d[0] = in_port;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      chain_d[i] = chain_q[i-1];
    end
    prev_d  = sync;
    prime_d = (prime_q != '0) ? prime_q - PRIME_W'(1) : prime_q;

    rise = sync & ~prev_q;
    fall = ~sync & prev_q;
    if (EDGE_TYPE == EDGE_FALL) begin
      sel = fall;
    end else if (EDGE_TYPE == EDGE_ANY) begin
      sel = rise | fall;
    end else begin
      sel = rise;
    end
    // Muted until the chain and prev hold real input, so a pin high at reset exit is not an edge.
    edge_pulse = (prime_q == '0) ? sel : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      chain_q <= '{default: '0};
      prev_q  <= '0;
      prime_q <= PRIME_LOAD;
    end else begin
      chain_q <= chain_d;
      prev_q  <= prev_d;
      prime_q <= prime_d;
    end
  end

endmodule

// File: rtl/nios2_pio_in_edge_irq.sv
// Avalon-MM input PIO: DATA / IRQMASK / EDGECAPTURE registers with a maskable level or edge irq.
// readdata registered (1-cycle latency from address); writes always accepted, no wait states.
module nios2_pio_in_edge_irq
  import nios2_pio_in_edge_irq_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE,
  parameter int IRQ_TYPE    = IRQ_EDGE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync, edge_pulse;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] wr_bits;
  logic [31:0]      rdata_q, rdata_d;
  logic             wr_en;
  logic             unused_wdata;

  assign unused_wdata = ^writedata;

  nios2_pio_sync_edge #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_TYPE  (EDGE_TYPE)
  ) u_sync_edge (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_port   (in_port),
    .sync      (sync),
    .edge_pulse(edge_pulse)
  );

  always_comb begin
    wr_en   = chipselect & ~write_n;
    wr_bits = writedata[WIDTH-1:0];

    mask_d = mask_q;
    if (wr_en && (pio_off_e'(address) == PIO_OFF_MASK)) begin
      mask_d = wr_bits;
    end

    // A new edge is OR-ed in after the clear so it survives a same-cycle clear.
    edge_d = edge_q;
    if (wr_en && (pio_off_e'(address) == PIO_OFF_EDGE)) begin
      edge_d = edge_q & ~wr_bits;
    end
    edge_d = edge_d | edge_pulse;

    rdata_d = '0;
    case (pio_off_e'(address))
      PIO_OFF_DATA: rdata_d[WIDTH-1:0] = sync;
      PIO_OFF_MASK: rdata_d[WIDTH-1:0] = mask_q;
      PIO_OFF_EDGE: rdata_d[WIDTH-1:0] = edge_q;
      default:      rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mask_q  <= '0;
      edge_q  <= '0;
      rdata_q <= '0;
    end else begin
      mask_q  <= mask_d;
      edge_q  <= edge_d;
      rdata_q <= rdata_d;
    end
  end

  assign readdata = rdata_q;
  assign irq      = (IRQ_TYPE == IRQ_LEVEL) ? |(sync & mask_q) : |(edge_q & mask_q);

endmodule

// File: tb/tb_nios2_pio_in_edge_irq.sv
// Directed bench: four instances (rise/edge-irq, rise/level-irq, fall, any) share one bus and in_port.
module tb_nios2_pio_in_edge_irq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] rd0, rd1, rd2, rd3;
  logic        irq0, irq1, irq2, irq3;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  nios2_pio_in_edge_irq #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_TYPE(1)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd0), .irq(irq0));

  nios2_pio_in_edge_irq #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_TYPE(0)) u_level (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd1), .irq(irq1));

  nios2_pio_in_edge_irq #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(1), .IRQ_TYPE(1)) u_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd2), .irq(irq2));

  nios2_pio_in_edge_irq #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(2), .IRQ_TYPE(1)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd3), .irq(irq3));

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 8'hFF;
    step(3);
    chk("reset_readdata", rd0, 32'h0);
    chk("reset_irq", {31'b0, irq0}, 32'h0);

    // Release with inputs high: DATA after 2 sync edges + 1 read edge, no captured edges.
    reset_n = 1'b1;
    step(2);
    chk("data_before_sync", rd0, 32'h0);
    step(1);
    chk("data_after_sync", rd0, 32'h0000_00FF);
    address = 2'd3;
    step(1);
    chk("prime_edge_rise", rd0, 32'h0);
    chk("prime_edge_any", rd3, 32'h0);
    chk("prime_irq", {31'b0, irq0}, 32'h0);

    // Read latency and upper writedata bits ignored.
    bus_wr(2'd1, 32'h0000_00A5);
    chk("mask_read_old", rd0, 32'h0);
    step(1);
    chk("mask_read_a5", rd0, 32'h0000_00A5);
    address = 2'd2;
    step(1);
    chk("rsvd_read", rd0, 32'h0);
    bus_wr(2'd1, 32'hFFFF_FF5A);
    step(1);
    chk("mask_wide_write", rd0, 32'h0000_005A);

    // Capture 0->05 with mask 04, then partial clear.
    bus_wr(2'd1, 32'h0000_0004);
    in_port = 8'h00;
    step(4);
    bus_wr(2'd3, 32'h0000_00FF);
    in_port = 8'h05;
    step(2);
    chk("irq_before_capture", {31'b0, irq0}, 32'h0);
    step(1);
    chk("irq_after_capture", {31'b0, irq0}, 32'h1);
    chk("level_irq_mask04", {31'b0, irq1}, 32'h1);
    step(1);
    chk("edge_05", rd0, 32'h0000_0005);
    chk("edge_fall_none", rd2, 32'h0);
    chk("edge_any_05", rd3, 32'h0000_0005);
    bus_wr(2'd3, 32'h0000_0004);
    chk("irq_after_clear", {31'b0, irq0}, 32'h0);
    step(1);
    chk("edge_after_clear", rd0, 32'h0000_0001);

    // Rising edge on bit0 lands on the same edge as a clear of bit0.
    in_port = 8'h04;
    step(4);
    bus_wr(2'd3, 32'h0000_0001);
    step(1);
    chk("edge_cleared", rd0, 32'h0);
    in_port = 8'h05;
    step(2);
    bus_wr(2'd3, 32'h0000_0001);
    step(1);
    chk("set_wins", rd0, 32'h0000_0001);
    step(1);
    chk("sticky", rd0, 32'h0000_0001);

    // Level irq follows synchronised bit7 under mask 80.
    bus_wr(2'd1, 32'h0000_0080);
    chk("level_irq_low", {31'b0, irq1}, 32'h0);
    in_port = 8'h85;
    step(1);
    chk("level_irq_1cyc", {31'b0, irq1}, 32'h0);
    step(1);
    chk("level_irq_high", {31'b0, irq1}, 32'h1);
    step(1);
    chk("edge_irq_bit7", {31'b0, irq0}, 32'h1);
    in_port = 8'h05;
    step(1);
    chk("level_irq_hold", {31'b0, irq1}, 32'h1);
    step(1);
    chk("level_irq_drop", {31'b0, irq1}, 32'h0);

    // Edge-type variants on 05 -> 0A.
    step(2);
    bus_wr(2'd3, 32'h0000_00FF);
    in_port = 8'h0A;
    step(4);
    chk("var_rise", rd0, 32'h0000_000A);
    chk("var_fall", rd2, 32'h0000_0005);
    chk("var_any", rd3, 32'h0000_000F);

    // Reserved write ignored.
    bus_wr(2'd2, 32'hFFFF_FFFF);
    step(1);
    chk("rsvd_write", rd0, 32'h0);

    // Fill EDGECAPTURE and mask, then reset mid-stream under an active write.
    bus_wr(2'd1, 32'h0000_00FF);
    in_port = 8'h00;
    step(4);
    in_port = 8'hFF;
    step(4);
    address = 2'd3;
    step(1);
    chk("edge_full", rd0, 32'h0000_00FF);
    chk("irq_full", {31'b0, irq0}, 32'h1);
    reset_n    = 1'b0;
    address    = 2'd1;
    writedata  = 32'hFFFF_FFFF;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step(1);
    chk("midreset_readdata", rd0, 32'h0);
    chk("midreset_irq", {31'b0, irq0}, 32'h0);
    chk("midreset_level_irq", {31'b0, irq1}, 32'h0);
    reset_n    = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    step(1);
    chk("midreset_mask", rd0, 32'h0);
    address = 2'd3;
    step(4);
    chk("midreset_edge", rd0, 32'h0);
    chk("midreset_irq_after", {31'b0, irq0}, 32'h0);
    address = 2'd0;
    step(1);
    chk("midreset_data", rd0, 32'h0000_00FF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
